// File: rtl/tone_sequencer.sv
// Melody player: walks a 16-entry tone ROM (duration, frequency) with a silent gap after each note.
// Optional TONE_SEQ_BTN_PREEMPT_EN lets a button press abort a running melody.
module tone_sequencer #(
    parameter int TICKS_PER_UNIT = 5000000,
    parameter int GAP_TICKS      = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        btn_pressed,
    input  logic [14:0] btn_frequency,
    output logic [3:0]  rom_addr,
    input  logic [17:0] rom_data,
    output logic        play,
    output logic [14:0] frequency,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PLAY   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // One counter serves both the note duration and the gap, so size it for the longer.
    localparam int MAX_T = (7 * TICKS_PER_UNIT > GAP_TICKS) ? 7 * TICKS_PER_UNIT : GAP_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [3:0]         addr_q, addr_d;
    logic               play_q, play_d;
    logic [14:0]        freq_q, freq_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               preempt;

`ifdef TONE_SEQ_BTN_PREEMPT_EN
    assign preempt = btn_pressed;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        limit_d = limit_q;
        addr_d  = addr_q;
        play_d  = play_q;
        freq_d  = freq_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                play_d = btn_pressed;
                freq_d = btn_pressed ? btn_frequency : 15'd0;
                if (start && !stop && !preempt) begin
                    state_d = S_FETCH;
                    addr_d  = 4'd0;
                    busy_d  = 1'b1;
                    play_d  = 1'b0;
                    freq_d  = 15'd0;
                end
            end
            S_FETCH: begin
                cnt_d = '0;
                if (rom_data[17:15] == 3'd0) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    play_d  = 1'b0;
                    freq_d  = 15'd0;
                end else begin
                    state_d = S_PLAY;
                    limit_d = CNT_W'(rom_data[17:15]) * CNT_W'(TICKS_PER_UNIT) - CNT_W'(1);
                    play_d  = (rom_data[14:0] != 15'd0);
                    freq_d  = rom_data[14:0];
                end
            end
            S_PLAY: begin
                if (cnt_q == limit_q) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    play_d  = 1'b0;
                    freq_d  = 15'd0;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                    cnt_d = '0;
                    // The last entry ends the melody instead of wrapping the address.
                    if (addr_q == 4'd15) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + 4'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                play_d  = 1'b0;
                freq_d  = 15'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                play_d  = 1'b0;
                freq_d  = 15'd0;
            end
        endcase

        // Abort from any active state; stop silences, a preempting button plays through.
        if (state_q != S_IDLE && (stop || preempt)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            play_d  = !stop;
            freq_d  = stop ? 15'd0 : btn_frequency;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            addr_q  <= 4'd0;
            play_q  <= 1'b0;
            freq_q  <= 15'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            addr_q  <= addr_d;
            play_q  <= play_d;
            freq_q  <= freq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr  = addr_q;
    assign play      = play_q;
    assign frequency = freq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: IDLE vector table, melody timelines from a ROM-walk model, and abort/reset corners.
module tb_tone_sequencer;

    localparam int TPU = 4;
    localparam int GAP = 2;
    localparam int W   = 23;   // {addr_dont_care, play, frequency[14:0], busy, done, rom_addr[3:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        btn_pressed = 1'b0;
    logic [14:0] btn_frequency = 15'd0;
    logic [3:0]  rom_addr;
    logic [17:0] rom_data;
    logic        play;
    logic [14:0] frequency;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    logic [17:0] rom [16];
    logic [W-1:0] exp_q[$];
    int tests = 0;
    int errors = 0;

    assign rom_data = rom[rom_addr];

    tone_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .btn_pressed(btn_pressed), .btn_frequency(btn_frequency),
        .rom_addr(rom_addr), .rom_data(rom_data), .play(play),
        .frequency(frequency), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pk(logic dc, logic p, logic [14:0] f, logic b, logic d, logic [3:0] a);
        return {dc, p, f, b, d, a};
    endfunction

    task automatic check(string name, logic [W-1:0] exp);
        logic [W-1:0] got;
        logic ok;
        got = {1'b0, play, frequency, busy, done, rom_addr};
        ok = exp[W-1] ? (got[21:4] == exp[21:4]) : (got[21:0] == exp[21:0]);
        tests++;
        if (!ok) begin
            errors++;
            $display("FAIL %s t=%0t got play=%0d freq=%0d busy=%0d done=%0d addr=%0d exp play=%0d freq=%0d busy=%0d done=%0d addr=%0d%s",
                     name, $time, got[21], got[20:6], got[5], got[4], got[3:0],
                     exp[21], exp[20:6], exp[5], exp[4], exp[3:0], exp[W-1] ? "(any)" : "");
        end
    endtask

    // Expected per-cycle outputs from cycle 1 after a start pulse, walking the ROM entry by entry.
    task automatic build_trace();
        int d;
        logic [14:0] f;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            d = int'(rom[i][17:15]);
            f = rom[i][14:0];
            exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 4'(i)));
            if (d == 0) begin
                exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 4'(i)));
                exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'(i)));
                return;
            end
            repeat (d * TPU) exp_q.push_back(pk(1'b0, f != 15'd0, f, 1'b1, 1'b0, 4'(i)));
            repeat (GAP) exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 4'(i)));
        end
        exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 4'd15));
        exp_q.push_back(pk(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'd15));
    endtask

    // stop_cyc: -1 none, 0 random, >0 assert stop during that cycle. btn_cyc: cycle with btn 880 (-1 none).
    task automatic run_melody(string name, int stop_cyc, int btn_cyc);
        int cyc;
        int sc;
        build_trace();
        sc = stop_cyc;
        if (sc == 0) sc = $urandom_range(1, exp_q.size() - 2);
        if (sc > 0 && sc < exp_q.size()) begin
            while (exp_q.size() > sc) void'(exp_q.pop_back());
            repeat (3) exp_q.push_back(pk(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0) begin
            check(name, exp_q.pop_front());
            stop          = (cyc == sc);
            btn_pressed   = (cyc == btn_cyc);
            btn_frequency = (cyc == btn_cyc) ? 15'd880 : 15'd0;
            step();
            cyc++;
        end
        stop = 1'b0;
        btn_pressed = 1'b0;
        btn_frequency = 15'd0;
    endtask

    typedef struct {
        logic        start;
        logic        stop;
        logic        btn;
        logic [14:0] bf;
        logic        e_play;
        logic [14:0] e_freq;
        logic        e_busy;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 15'd0,     1'b0, 15'd0,     1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 15'd880,   1'b1, 15'd880,   1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 15'd0,     1'b1, 15'd0,     1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 15'd0,     1'b0, 15'd0,     1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 15'd1234,  1'b1, 15'd1234,  1'b0};
`ifdef TONE_SEQ_BTN_PREEMPT_EN
        vecs[5] = '{1'b1, 1'b0, 1'b1, 15'd700,   1'b1, 15'd700,   1'b0};
`else
        vecs[5] = '{1'b1, 1'b0, 1'b1, 15'd700,   1'b0, 15'd0,     1'b1};
`endif
        vecs[6] = '{1'b0, 1'b1, 1'b1, 15'd32767, 1'b1, 15'd32767, 1'b0};

        for (int i = 0; i < 16; i++) rom[i] = 18'd0;

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        check("reset_async", pk(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0));
        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset_idle", pk(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0));

        // IDLE behaviour table: one cycle of input, outputs registered one cycle later.
        for (int i = 0; i < 7; i++) begin
            start = vecs[i].start;
            stop = vecs[i].stop;
            btn_pressed = vecs[i].btn;
            btn_frequency = vecs[i].bf;
            step();
            check($sformatf("idle_vec%0d", i),
                  pk(1'b1, vecs[i].e_play, vecs[i].e_freq, vecs[i].e_busy, 1'b0, 4'd0));
            start = 1'b0;
            btn_pressed = 1'b0;
            btn_frequency = 15'd0;
            stop = 1'b1;
            step();
            stop = 1'b0;
            step();
        end

        // Single note then end marker.
        rom[0] = {3'd2, 15'd440};
        rom[1] = {3'd0, 15'd0};
        run_melody("single_note", -1, -1);

        // Rest followed by a tone.
        rom[0] = {3'd1, 15'd0};
        rom[1] = {3'd1, 15'd262};
        rom[2] = {3'd0, 15'd0};
        run_melody("rest_then_tone", -1, -1);

        // Full ROM: sixteen notes, no wrap to entry 0.
        for (int i = 0; i < 16; i++) rom[i] = {3'd1, 15'd500};
        run_melody("full_rom", -1, -1);

        // Stop during the third PLAY cycle.
        for (int i = 0; i < 16; i++) rom[i] = 18'd0;
        rom[0] = {3'd2, 15'd440};
        run_melody("stop_play3", 4, -1);

        // Button during PLAY.
`ifdef TONE_SEQ_BTN_PREEMPT_EN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        btn_pressed = 1'b1;
        btn_frequency = 15'd880;
        step();
        check("btn_preempt", pk(1'b1, 1'b1, 15'd880, 1'b0, 1'b0, 4'd0));
        btn_pressed = 1'b0;
        btn_frequency = 15'd0;
        step();
        check("btn_preempt_after", pk(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0));
        step();
`else
        run_melody("btn_ignored", -1, 3);
`endif

        // Reset in the middle of the second note, then replay from entry 0.
        rom[0] = {3'd1, 15'd300};
        rom[1] = {3'd2, 15'd440};
        rom[2] = {3'd0, 15'd0};
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("pre_reset_play", pk(1'b0, 1'b1, 15'd440, 1'b1, 1'b0, 4'd1));
        #2 rst_n = 1'b0;
        #1;
        check("reset_midplay", pk(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 4'd0));
        step();
        rst_n = 1'b1;
        step();
        run_melody("replay_after_reset", -1, -1);

        // Randomized melodies, some aborted at a random cycle.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i][17:15] = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                rom[i][14:0]  = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(1, 32767));
            end
            run_melody($sformatf("random%0d", r), ($urandom_range(0, 1) == 1) ? 0 : -1, -1);
            repeat ($urandom_range(1, 4)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
